// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if
// Request/response bundle between a load/store master and dmem_responder.
//   req_valid  : request present (master -> responder)
//   req_ready  : responder can accept a request (responder -> master)
//   req_we     : 1 = store, 0 = load
//   req_funct3 : RV32I width/sign code
//   req_addr   : byte address
//   req_wdata  : store data, right-aligned
//   rsp_valid  : one-cycle response strobe
//   rsp_rdata  : extended load data (0 for stores and errors)
//   rsp_err    : access rejected, qualified by rsp_valid
// ----------------------------------------------------------------------------
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Memory-side endpoint for RV32I loads and stores. Accepts one request at a
// time, waits WAIT_CYCLES cycles, then commits a byte-masked store or returns
// a sign/zero-extended load in a single-cycle response. Misaligned, unknown
// or out-of-range accesses raise rsp_err and leave memory untouched.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dmem_if slave modport (request handshake + response)
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES : wait states between accept and response (0 allowed)
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic              ready_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;
  logic [31:0]       mem_r [DEPTH_WORDS];

  logic              sel_we_s;
  logic [2:0]        sel_funct3_s;
  logic [31:0]       sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic              accept_s;
  logic              commit_s;
  logic              err_s;
  logic              mem_we_s;
  logic [AW-1:0]     idx_s;
  logic [31:0]       word_s;
  logic [31:0]       load_data_s;
  logic [31:0]       store_data_s;
  logic [3:0]        store_mask_s;

  // Unknown codes, stores with unsigned-load codes, misalignment, out of range.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic bad_code;
    logic bad_align;
    logic bad_range;
    bad_code  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                (we && f3[2]);
    bad_align = ((f3[1:0] == 2'b01) && addr[0]) ||
                ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad_range = (addr >> (AW + 2)) != 32'd0;
    return bad_code || bad_align || bad_range;
  endfunction

  // Select the addressed byte/half from a little-endian word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = 8'(word >> {lane, 3'b000});
    half_v = 16'(word >> {lane[1], 4'b0000});
    case (f3)
      3'b000:  res = {{24{byte_v[7]}}, byte_v};
      3'b001:  res = {{16{half_v[15]}}, half_v};
      3'b010:  res = word;
      3'b100:  res = {24'd0, byte_v};
      3'b101:  res = {16'd0, half_v};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Byte lanes touched by a store of the given width at the given lane.
  function automatic logic [3:0] store_mask(input logic [1:0] size,
                                            input logic [1:0] lane);
    logic [3:0] res;
    case (size)
      2'b00:   res = 4'b0001 << lane;
      2'b01:   res = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   res = 4'b1111;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  // Replicate right-aligned store data across all lanes; the mask picks lanes.
  function automatic logic [31:0] store_data(input logic [1:0] size,
                                             input logic [31:0] wdata);
    logic [31:0] res;
    case (size)
      2'b00:   res = {4{wdata[7:0]}};
      2'b01:   res = {2{wdata[15:0]}};
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Live request in IDLE (needed when WAIT_CYCLES=0 commits on the accept edge), latched request otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      sel_we_s     = bus.req_we;
      sel_funct3_s = bus.req_funct3;
      sel_addr_s   = bus.req_addr;
      sel_wdata_s  = bus.req_wdata;
    end else begin
      sel_we_s     = we_r;
      sel_funct3_s = funct3_r;
      sel_addr_s   = addr_r;
      sel_wdata_s  = wdata_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_next_s = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: accept/commit strobes plus access decode of the selected request.
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && bus.req_valid;
    commit_s     = (state_next_s == ST_RESP) && (state_r != ST_RESP);
    idx_s        = sel_addr_s[AW+1:2];
    word_s       = mem_r[idx_s];
    err_s        = access_err(sel_we_s, sel_funct3_s, sel_addr_s);
    mem_we_s     = commit_s && sel_we_s && !err_s;
    store_mask_s = store_mask(sel_funct3_s[1:0], sel_addr_s[1:0]);
    store_data_s = store_data(sel_funct3_s[1:0], sel_wdata_s);
    if (err_s || sel_we_s) begin
      load_data_s = 32'd0;
    end else begin
      load_data_s = load_extend(sel_funct3_s, sel_addr_s[1:0], word_s);
    end
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      cnt_r    <= CNT_ZERO;
    end else if (accept_s) begin
      we_r     <= bus.req_we;
      funct3_r <= bus.req_funct3;
      addr_r   <= bus.req_addr;
      wdata_r  <= bus.req_wdata;
      cnt_r    <= CNT_LOAD;
    end else if ((state_r == ST_WAIT) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // Registered handshake/response outputs; the response is live only in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      ready_r     <= (state_next_s == ST_IDLE);
      rsp_valid_r <= commit_s;
      rsp_rdata_r <= commit_s ? load_data_s : 32'd0;
      rsp_err_r   <= commit_s && err_s;
    end
  end

  // Storage: no writes while reset is held; contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (store_mask_s[b]) begin
          mem_r[idx_s][b*8 +: 8] <= store_data_s[b*8 +: 8];
        end
      end
    end
  end

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder: one instance with WAIT_CYCLES=2 (main
// function, errors, reset behaviour) and one with WAIT_CYCLES=0
// (back-to-back throughput). Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  dmem_if bus2 ();
  dmem_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  // One request on the WAIT_CYCLES=2 instance; lat = falling edges from accept to rsp_valid (-1 on timeout).
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_funct3 = f3;
    bus2.req_addr = addr; bus2.req_wdata = wdata;
    @(posedge clk); #1;
    bus2.req_valid = 1'b0;
    lat = -1; rdata = 32'd0; err = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid === 1'b1) begin
        lat = i; rdata = bus2.rsp_rdata; err = bus2.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = 3'b010;
    bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b010;
    bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus2.req_ready !== 1'b1 || bus2.rsp_valid !== 1'b0 || bus2.rsp_rdata !== 32'd0 ||
          bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0 || bus0.rsp_rdata !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold got ready=%b/%b valid=%b/%b rdata=%h/%h want 1 0 0",
                 bus2.req_ready, bus0.req_ready, bus2.rsp_valid, bus0.rsp_valid,
                 bus2.rsp_rdata, bus0.rsp_rdata);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus2.req_ready !== 1'b0) begin
      errors++; $display("FAIL first_accept_w2 got ready=%b want 0", bus2.req_ready);
    end
    checks++;
    if (bus0.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL first_accept_w0 got rsp_valid=%b want 1", bus0.rsp_valid);
    end
    bus2.req_valid = 1'b0;
    bus0.req_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin
      errors++; $display("FAIL sw_word got lat=%0d err=%b rdata=%h want 3 0 00000000", lat, er, rd);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL lw_latency got %0d want 3", lat);
    end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_word got rdata=%h err=%b want deadbeef 0", rd, er);
    end
  endtask

  task automatic test_byte_half();
    vec_t v[$];
    logic [31:0] rd; logic er; int lat;
    v.push_back('{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h00000000, 1'b0});
    v.push_back('{1'b1, 3'b000, 32'h21, 32'h123456AA, 32'h00000000, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'h20, 32'h0,        32'h1122AA44, 1'b0});
    v.push_back('{1'b0, 3'b000, 32'h21, 32'h0,        32'hFFFFFFAA, 1'b0});
    v.push_back('{1'b0, 3'b100, 32'h21, 32'h0,        32'h000000AA, 1'b0});
    v.push_back('{1'b1, 3'b001, 32'h22, 32'h77778001, 32'h00000000, 1'b0});
    v.push_back('{1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 1'b0});
    v.push_back('{1'b0, 3'b101, 32'h22, 32'h0,        32'h00008001, 1'b0});
    v.push_back('{1'b0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 1'b0});
    v.push_back('{1'b0, 3'b001, 32'h20, 32'h0,        32'hFFFFAA44, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'h20, 32'h0,        32'h8001AA44, 1'b0});
    foreach (v[i]) begin
      run_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat);
      checks++;
      if (lat !== 3 || rd !== v[i].rdata || er !== v[i].err) begin
        errors++;
        $display("FAIL byte_half[%0d] got lat=%0d rdata=%h err=%b want 3 %h %b",
                 i, lat, rd, er, v[i].rdata, v[i].err);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[$];
    logic [31:0] rd; logic er; int lat;
    v.push_back('{1'b0, 3'b010, 32'h12,       32'h0,        32'h00000000, 1'b1});
    v.push_back('{1'b1, 3'b001, 32'h23,       32'hBEEF,     32'h00000000, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'h20,       32'h0,        32'h8001AA44, 1'b0});
    v.push_back('{1'b0, 3'b011, 32'h20,       32'h0,        32'h00000000, 1'b1});
    v.push_back('{1'b1, 3'b011, 32'h20,       32'h0,        32'h00000000, 1'b1});
    v.push_back('{1'b1, 3'b100, 32'h20,       32'hFF,       32'h00000000, 1'b1});
    v.push_back('{1'b1, 3'b101, 32'h20,       32'hFFFF,     32'h00000000, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'h20,       32'h0,        32'h8001AA44, 1'b0});
    v.push_back('{1'b0, 3'b001, 32'h21,       32'h0,        32'h00000000, 1'b1});
    v.push_back('{1'b0, 3'b110, 32'h20,       32'h0,        32'h00000000, 1'b1});
    v.push_back('{1'b0, 3'b111, 32'h20,       32'h0,        32'h00000000, 1'b1});
    v.push_back('{1'b1, 3'b010, 32'h0,        32'h0,        32'h00000000, 1'b0});
    v.push_back('{1'b1, 3'b010, 32'h400,      32'h77,       32'h00000000, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'h400,      32'h0,        32'h00000000, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'h0,        32'h0,        32'h00000000, 1'b0});
    v.push_back('{1'b1, 3'b010, 32'h3FC,      32'hCAFEF00D, 32'h00000000, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'h3FC,      32'h0,        32'hCAFEF00D, 1'b0});
    v.push_back('{1'b0, 3'b100, 32'h3FF,      32'h0,        32'h000000CA, 1'b0});
    v.push_back('{1'b1, 3'b010, 32'hFFFFFFFC, 32'h1,        32'h00000000, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'h3FC,      32'h0,        32'hCAFEF00D, 1'b0});
    foreach (v[i]) begin
      run_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat);
      checks++;
      if (lat !== 3 || rd !== v[i].rdata || er !== v[i].err) begin
        errors++;
        $display("FAIL errors[%0d] got lat=%0d rdata=%h err=%b want 3 %h %b",
                 i, lat, rd, er, v[i].rdata, v[i].err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; logic seen;
    // WAIT_CYCLES=0 instance with req_valid held: accept every other cycle.
    @(negedge clk);
    checks++;
    if (bus0.req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle_ready got %b want 1", bus0.req_ready);
    end
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_funct3 = 3'b010;
    bus0.req_addr = 32'h8; bus0.req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if (bus0.rsp_valid !== 1'b1 || bus0.req_ready !== 1'b0 || bus0.rsp_err !== 1'b0) begin
      errors++; $display("FAIL b2b_sw_resp got valid=%b ready=%b err=%b want 1 0 0",
                         bus0.rsp_valid, bus0.req_ready, bus0.rsp_err);
    end
    bus0.req_we = 1'b0; bus0.req_funct3 = 3'b010; bus0.req_addr = 32'h8;
    @(negedge clk);
    checks++;
    if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap1 got ready=%b valid=%b want 1 0", bus0.req_ready, bus0.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus0.rsp_valid !== 1'b1 || bus0.req_ready !== 1'b0 || bus0.rsp_rdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL b2b_lw_resp got valid=%b ready=%b rdata=%h want 1 0 a5a5a5a5",
                         bus0.rsp_valid, bus0.req_ready, bus0.rsp_rdata);
    end
    bus0.req_funct3 = 3'b100; bus0.req_addr = 32'h9;
    @(negedge clk);
    checks++;
    if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap2 got ready=%b valid=%b want 1 0", bus0.req_ready, bus0.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== 32'h000000A5) begin
      errors++; $display("FAIL b2b_lbu_resp got valid=%b rdata=%h want 1 000000a5",
                         bus0.rsp_valid, bus0.rsp_rdata);
    end
    bus0.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got ready=%b valid=%b want 1 0", bus0.req_ready, bus0.rsp_valid);
    end

    // WAIT_CYCLES=2 instance: request fields change mid-WAIT and must not be latched.
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_funct3 = 3'b010;
    bus2.req_addr = 32'h10; bus2.req_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if (bus2.req_ready !== 1'b0) begin
      errors++; $display("FAIL midwait_ready got %b want 0", bus2.req_ready);
    end
    bus2.req_we = 1'b1; bus2.req_funct3 = 3'b000; bus2.req_addr = 32'h20;
    seen = 1'b0; rd = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid === 1'b1) begin
        seen = 1'b1; rd = bus2.rsp_rdata;
        bus2.req_valid = 1'b0;
        break;
      end
    end
    bus2.req_valid = 1'b0;
    checks++;
    if (seen !== 1'b1 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL midwait_latch got seen=%b rdata=%h want 1 deadbeef", seen, rd);
    end
    run_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== 32'h8001AA44 || er !== 1'b0) begin
      errors++; $display("FAIL midwait_nowrite got lat=%0d rdata=%h err=%b want 3 8001aa44 0", lat, rd, er);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic seen;
    run_req(1'b1, 3'b010, 32'h30, 32'h0, rd, er, lat);
    run_req(1'b1, 3'b010, 32'h34, 32'h0, rd, er, lat);
    // Reset during WAIT of an uncommitted store.
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_funct3 = 3'b010;
    bus2.req_addr = 32'h30; bus2.req_wdata = 32'h55;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus2.req_ready !== 1'b1 || bus2.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_in got ready=%b valid=%b want 1 0", bus2.req_ready, bus2.rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || bus2.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_wait_after got stray_valid=%b ready=%b want 0 1", seen, bus2.req_ready);
    end
    run_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL rst_wait_mem got lat=%0d rdata=%h err=%b want 3 00000000 0", lat, rd, er);
    end
    // Reset during RESP of a store that has already committed.
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_funct3 = 3'b010;
    bus2.req_addr = 32'h34; bus2.req_wdata = 32'h66;
    @(negedge clk);
    bus2.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus2.rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL rst_resp_seen got %b want 1", seen);
    end
    run_req(1'b0, 3'b010, 32'h34, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 3 || rd !== 32'h66 || er !== 1'b0) begin
      errors++; $display("FAIL rst_resp_mem got lat=%0d rdata=%h err=%b want 3 00000066 0", lat, rd, er);
    end
  endtask

  initial begin
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_funct3 = 3'b000;
    bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b000;
    bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
